mod_mul_seq: RTL
================

# mod_mul_seq

Sequential modular multiplier computing OUT = (A × B) mod P with an iterative MSB-first interleaved shift-add-reduce datapath, one multiplier bit per cycle. It performs the forward field operation that undoes the combinational modular inverse in the elliptic-curve group datapath: for inverse pairs, mod_mul_seq(x, inv(x), p) returns 1. The ECC point-add/double controllers use it for slope and coordinate products. A valid/busy handshake governs operand capture and result delivery.

## Interface
- IP_WIDTH, 6, width of operands, modulus and result

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid; sampled only in IDLE
- in_a  input  IP_WIDTH  multiplicand A (unsigned)
- in_b  input  IP_WIDTH  multiplier B (unsigned)
- in_p  input  IP_WIDTH  modulus P (unsigned)
- busy  output  1  high whenever state ≠ IDLE
- out_valid  output  1  one-cycle result strobe
- out_data  output  IP_WIDTH  result; 0 whenever out_valid is low

## Operation
- States: IDLE, LOAD, CALC, DONE.
- IDLE:
  - in_valid=1 captures in_a, in_b, in_p into registers and moves to LOAD.
  - in_valid=0 stays in IDLE.
- LOAD:
  - Registers a_r = A mod P and b_r = B mod P (combinational `%`).
  - acc ← 0; bit counter cnt ← IP_WIDTH-1.
  - If P ≤ 1: a_r = b_r = 0, so the result is 0. P=0 must not divide by zero; gate the `%` and force 0.
  - Moves to CALC.
- CALC, one step per cycle:
  - d = {acc,1'b0} at IP_WIDTH+1 bits; if d ≥ P then d = d − P.
  - If b_r[cnt] = 1: s = d + a_r at IP_WIDTH+1 bits; if s ≥ P then s = s − P.
  - acc ← s or d (low IP_WIDTH bits; the value is always < P).
  - If cnt = 0, go to DONE; otherwise cnt ← cnt − 1.
- DONE:
  - out_valid=1 and out_data=acc for exactly one cycle.
  - Then returns to IDLE.
- Arithmetic is unsigned throughout. Intermediates are IP_WIDTH+1 bits, so no overflow is possible since acc, a_r < P.
- in_valid outside IDLE, including the DONE cycle, is ignored. No queuing.
- Input values change after capture and have no effect on the operation in flight.

## Timing
- Reset (rst=1 at a rising edge):
  - State = IDLE; busy=0; out_valid=0; out_data=0.
  - acc, cnt and operand registers are cleared.
  - Reset overrides every other action in the same cycle.
- Reset mid-operation aborts the computation with no result strobe. The next accepted in_valid starts cleanly.
- Latency: in_valid high in cycle 0 → LOAD in cycle 1 → CALC in cycles 2…IP_WIDTH+1 → out_valid in cycle IP_WIDTH+2. That is cycle 8 for IP_WIDTH=6.
- busy rises in cycle 1 and falls in cycle IP_WIDTH+3, when the block is back in IDLE.
- Throughput: one operation per IP_WIDTH+3 cycles. Earliest next acceptance is in_valid in cycle IP_WIDTH+3.
- All outputs are registered; no combinational input→output path.

## Test plan
- Inverse check:
  - Stimulus: IP_WIDTH=6, A=7, B=25, P=29, in_valid pulsed in cycle 0.
  - Required: out_valid=1 only in cycle 8, out_data=1; busy high in cycles 1–8.
- Unreduced operands and boundary value:
  - A=63, B=63, P=61 → out_data=4.
  - A=60, B=60, P=61 → out_data=1.
  - A=0, B=45, P=61 → out_data=0.
- Degenerate modulus:
  - P=0, A=5, B=9 → out_data=0, out_valid still in cycle 8, no X propagation.
  - P=1 → out_data=0.
- Busy rejection:
  - Start A=12, B=17, P=29. Assert in_valid with A=3, B=3, P=7 in cycles 3 and 8.
  - Required: single strobe in cycle 8 with out_data=1; no second strobe.
  - Then in_valid in cycle 9 with A=3, B=3, P=7 → out_data=2 in cycle 17.
- Mid-operation reset:
  - rst=1 in cycle 4 of an operation.
  - Required: busy=0, out_valid=0 and out_data=0 from the next cycle; no strobe for the aborted operation.
  - Then A=5, B=6, P=7 → out_data=2 exactly 8 cycles after acceptance.
- Randomized sweep: 2000 random (A, B, P) with P ≥ 2, compared against a (A×B) mod P reference model. Between strobes, out_data=0.

Source files
------------

// File: rtl/mod_mul_seq_if.sv
// Operand/result handshake bundle for the sequential modular multiplier.
interface mod_mul_seq_if #(
  parameter int unsigned IP_WIDTH = 6
) ();
  logic                in_valid;
  logic [IP_WIDTH-1:0] in_a;
  logic [IP_WIDTH-1:0] in_b;
  logic [IP_WIDTH-1:0] in_p;
  logic                busy;
  logic                out_valid;
  logic [IP_WIDTH-1:0] out_data;

  // Requester side: supplies operands, observes status and result
  modport master (
    output in_valid, in_a, in_b, in_p,
    input  busy, out_valid, out_data
  );

  // Multiplier side
  modport slave (
    input  in_valid, in_a, in_b, in_p,
    output busy, out_valid, out_data
  );
endinterface

// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier: OUT = (A * B) mod P, MSB-first interleaved
// shift-add-reduce, one multiplier bit per cycle.
module mod_mul_seq #(
  parameter int unsigned IP_WIDTH = 6
) (
  input  logic         clk,
  input  logic         rst,
  mod_mul_seq_if.slave bus
);
  localparam int unsigned W     = IP_WIDTH;
  localparam int unsigned W1    = IP_WIDTH + 1;
  localparam int unsigned CNT_W = (IP_WIDTH > 1) ? $clog2(IP_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     p_q, p_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;

  logic [W1-1:0]    p_ext;
  logic [W1-1:0]    dbl;
  logic [W-1:0]     dbl_red;
  logic [W1-1:0]    sum;
  logic [W-1:0]     sum_red;

  // One reduction step: acc*2 mod P, then optionally + a_r mod P
  always_comb begin
    p_ext   = {1'b0, p_q};
    dbl     = {acc_q, 1'b0};
    dbl_red = (dbl >= p_ext) ? W'(dbl - p_ext) : W'(dbl);
    sum     = {1'b0, dbl_red} + {1'b0, a_q};
    sum_red = (sum >= p_ext) ? W'(sum - p_ext) : W'(sum);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          p_d     = bus.in_p;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // P of 0 or 1 forces zero operands; also keeps % away from P=0
        if (p_q > W'(1)) begin
          a_d = a_q % p_q;
          b_d = b_q % p_q;
        end else begin
          a_d = '0;
          b_d = '0;
        end
        acc_d   = '0;
        cnt_d   = CNT_W'(IP_WIDTH - 1);
        state_d = CALC;
      end
      CALC: begin
        acc_d = b_q[cnt_q] ? sum_red : dbl_red;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
    out_data_d  = (state_d == DONE) ? acc_d : '0;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_q         <= p_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule
